// File: rtl/cnn_layer_sched.sv
// Layer/block scheduler: walks four CNN stages, issuing blocks over a start/done handshake.
// Optional busy-cycle counter on perf_cycles is built only when CNN_SCHED_PERF_EN is defined.
module cnn_layer_sched #(
  parameter int L0_BLOCKS = 169,
  parameter int L1_BLOCKS = 121,
  parameter int L2_BLOCKS = 81,
  parameter int L3_BLOCKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control_reg,
  input  logic        blk_done,
  input  logic        wr_idle,
  output logic        blk_start,
  output logic [1:0]  layer,
  output logic [15:0] blk_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] status,
  output logic [31:0] perf_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  layer_reg, layer_next;
  logic [15:0] idx_reg, idx_next;
  logic        ctrl_q;
  logic        done_sticky_reg, err_sticky_reg, abort_sticky_reg;
  logic        start_evt, abort_req, run_start, last_blk;
  logic [15:0] last_idx;
  logic        unused_ctrl;

  assign start_evt   = control_reg[1] & ~ctrl_q;
  assign abort_req   = control_reg[2];
  assign unused_ctrl = ^{control_reg[31:3], control_reg[0]};
  // Abort in IDLE swallows a coincident start event.
  assign run_start   = (state_reg == S_IDLE) && start_evt && !abort_req;

  always_comb begin
    case (layer_reg)
      2'd0:    last_idx = 16'(L0_BLOCKS - 1);
      2'd1:    last_idx = 16'(L1_BLOCKS - 1);
      2'd2:    last_idx = 16'(L2_BLOCKS - 1);
      default: last_idx = 16'(L3_BLOCKS - 1);
    endcase
  end

  assign last_blk = (idx_reg == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      layer_reg <= 2'd0;
      idx_reg   <= 16'd0;
      ctrl_q    <= 1'b0;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
      idx_reg   <= idx_next;
      ctrl_q    <= control_reg[1];
    end
  end

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    idx_next   = idx_reg;
    if (state_reg != S_IDLE && abort_req) begin
      state_next = S_IDLE;
      layer_next = 2'd0;
      idx_next   = 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (run_start) begin
            state_next = S_ISSUE;
            layer_next = 2'd0;
            idx_next   = 16'd0;
          end
        end
        S_ISSUE: state_next = S_WAIT;
        S_WAIT: begin
          if (blk_done) begin
            if (last_blk) begin
              state_next = S_DRAIN;
            end else begin
              idx_next   = idx_reg + 16'd1;
              state_next = S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (wr_idle) begin
            if (layer_reg == 2'd3) begin
              state_next = S_DONE;
            end else begin
              layer_next = layer_reg + 2'd1;
              idx_next   = 16'd0;
              state_next = S_ISSUE;
            end
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    blk_start = (state_reg == S_ISSUE);
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
  end

  // Sticky flags: a new run clears all three, otherwise they only ever set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_sticky_reg  <= 1'b0;
      err_sticky_reg   <= 1'b0;
      abort_sticky_reg <= 1'b0;
    end else if (run_start) begin
      done_sticky_reg  <= 1'b0;
      err_sticky_reg   <= 1'b0;
      abort_sticky_reg <= 1'b0;
    end else begin
      if (blk_done && state_reg != S_WAIT)
        err_sticky_reg <= 1'b1;
      if (abort_req && state_reg != S_IDLE)
        abort_sticky_reg <= 1'b1;
      if (state_reg == S_DONE && !abort_req)
        done_sticky_reg <= 1'b1;
    end
  end

  assign layer   = layer_reg;
  assign blk_idx = idx_reg;
  assign status  = {busy, done_sticky_reg, err_sticky_reg, abort_sticky_reg,
                    10'd0, layer_reg, idx_reg};

`ifdef CNN_SCHED_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perf_reg <= 32'd0;
    else if (run_start)
      perf_reg <= 32'd0;
    else if (state_reg != S_IDLE && perf_reg != 32'hFFFF_FFFF)
      perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Randomized bench for cnn_layer_sched; expectations come from block counts and
// per-block/per-stage latencies chosen by the bench itself.
module tb_cnn_layer_sched;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 3;
  localparam int L3 = 1;
  localparam int NBLK = L0 + L1 + L2 + L3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] control_reg = 32'd0;
  logic        blk_done = 1'b0;
  logic        wr_idle = 1'b1;
  logic        blk_start;
  logic [1:0]  layer;
  logic [15:0] blk_idx;
  logic        busy;
  logic        done;
  logic [31:0] status;
  logic [31:0] perf_cycles;

  int tests_run = 0;
  int tests_failed = 0;
  int n_start = 0;
  int n_busy = 0;
  int n_done = 0;

  cnn_layer_sched #(
    .L0_BLOCKS(L0), .L1_BLOCKS(L1), .L2_BLOCKS(L2), .L3_BLOCKS(L3)
  ) dut (
    .clk(clk), .reset(reset), .control_reg(control_reg),
    .blk_done(blk_done), .wr_idle(wr_idle),
    .blk_start(blk_start), .layer(layer), .blk_idx(blk_idx),
    .busy(busy), .done(done), .status(status), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally the DUT's pulse outputs.
  task automatic tick();
    @(negedge clk);
    if (blk_start === 1'b1) n_start++;
    if (busy === 1'b1) n_busy++;
    if (done === 1'b1) n_done++;
  endtask

  task automatic wait_start(output int gap);
    gap = 0;
    while (blk_start !== 1'b1 && gap < 50) begin
      tick();
      gap++;
    end
  endtask

  function automatic int nblk(input int l);
    return (l == 0) ? L0 : (l == 1) ? L1 : (l == 2) ? L2 : L3;
  endfunction

  // fixed_d: blk_done latency after blk_start (0 = random 1..4).
  // stall0: <0 random drain stalls; otherwise stage 0 stalls that long, others 0.
  // abort_blk: linear block index whose blk_done coincides with abort (-1 = none).
  task automatic do_run(input int fixed_d, input int stall0, input int abort_blk);
    int d, s, gap, k, s_start0, b_start0, d_start0, stall_ref, exp_busy;
    logic [31:0] exp_status;
    control_reg = 32'd0;
    tick();
    control_reg = 32'h2;
    s_start0 = n_start;
    b_start0 = n_busy;
    d_start0 = n_done;
    exp_busy = 1;
    k = 0;
    tick();
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < nblk(l); i++) begin
        wait_start(gap);
        check_eq("start_gap", gap, 0);
        check_eq("layer", 32'(layer), l);
        check_eq("blk_idx", 32'(blk_idx), i);
        exp_status = {1'b1, 3'b000, 10'd0, 2'(l), 16'(i)};
        check_eq("status_blk", status, exp_status);
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
        exp_busy += 1 + d;
        repeat (d) tick();
        blk_done = 1'b1;
        if (k == abort_blk) control_reg = 32'h4;
        tick();
        blk_done = 1'b0;
        if (k == abort_blk) begin
          check_eq("abort_busy", 32'(busy), 0);
          check_eq("abort_status", status, 32'h1000_0000);
          stall_ref = n_start;
          repeat (8) tick();
          check_eq("abort_no_start", n_start - stall_ref, 0);
          check_eq("abort_idle", 32'(busy), 0);
          return;
        end
        if (i == nblk(l) - 1) begin
          s = (stall0 < 0) ? int'($urandom_range(0, 3)) : ((l == 0) ? stall0 : 0);
          exp_busy += 1 + s;
          stall_ref = n_start;
          for (int j = 0; j < s; j++) begin
            wr_idle = 1'b0;
            tick();
          end
          wr_idle = 1'b1;
          check_eq("stall_no_start", n_start - stall_ref, 0);
          tick();
        end
        k++;
      end
    end
    check_eq("done_pulse", 32'(done), 1);
    check_eq("done_busy", 32'(busy), 1);
    tick();
    check_eq("end_busy", 32'(busy), 0);
    check_eq("end_done", 32'(done), 0);
    exp_status = {1'b0, 1'b1, 2'b00, 10'd0, 2'd3, 16'(L3 - 1)};
    check_eq("end_status", status, exp_status);
    check_eq("start_count", n_start - s_start0, NBLK);
    check_eq("done_count", n_done - d_start0, 1);
    check_eq("busy_cycles", n_busy - b_start0, exp_busy);
`ifdef CNN_SCHED_PERF_EN
    check_eq("perf", perf_cycles, exp_busy);
`else
    check_eq("perf_off", perf_cycles, 0);
`endif
  endtask

  initial begin
    int ref_start;
    // Power-on reset.
    tick();
    check_eq("rst_out", {blk_start, busy, done, layer, blk_idx}, 0);
    check_eq("rst_status", status, 0);
    check_eq("rst_perf", perf_cycles, 0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_status", status, 0);

    // Spurious blk_done in IDLE.
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check_eq("spur_status", status, 32'h2000_0000);
    tick();
    check_eq("spur_idle", 32'(busy), 0);

    // Full run with fixed latency and no drain stall, start left held high.
    do_run(3, 0, -1);
    ref_start = n_start;
    repeat (10) tick();
    check_eq("held_no_rerun", n_start - ref_start, 0);
    check_eq("held_idle", 32'(busy), 0);

    // Restart (clears done_sticky), then drain stall, then abort collision.
    do_run(0, -1, -1);
    do_run(0, 20, -1);
    do_run(0, -1, L0 + L1 + int'($urandom_range(0, L2 - 1)));

    // Reset asserted mid-WAIT.
    control_reg = 32'd0;
    tick();
    control_reg = 32'h2;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_out", {blk_start, busy, done, layer, blk_idx}, 0);
    check_eq("async_rst_status", status, 0);
    check_eq("async_rst_perf", perf_cycles, 0);
    control_reg = 32'd0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("rel_status", status, 0);
    check_eq("rel_busy", 32'(busy), 0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) do_run(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnn_layer_sched.md
# cnn_layer_sched

Layer and block scheduler for the CNN accelerator datapath. It sits between the HPS-visible control register and the per-block memory read/MAC sequencer. On a start command it walks the four network stages in order (conv+pool, conv+pool, conv, dense) and, within each stage, issues one block at a time over a start/done handshake. Between stages it waits for write-back to drain. It reports progress and completion through a status word and a done pulse.

## Interface
Parameters:
- `L0_BLOCKS`, default 169: block count for stage 0 (conv1 + maxpool, 13x13 output positions). Must be ≥1.
- `L1_BLOCKS`, default 121: block count for stage 1 (conv2 + maxpool). Must be ≥1.
- `L2_BLOCKS`, default 81: block count for stage 2 (conv3 + ReLU). Must be ≥1.
- `L3_BLOCKS`, default 10: block count for stage 3 (dense, one block per output neuron). Must be ≥1.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `control_reg`, input, 32: HPS command word. Bit 1 is start (rising edge). Bit 2 is abort (level). Other bits are ignored.
- `blk_done`, input, 1: one-cycle pulse from the datapath when the current block is finished.
- `wr_idle`, input, 1: high when the result write-back path is empty.
- `blk_start`, output, 1: one-cycle pulse that launches a block.
- `layer`, output, 2: current stage, 0–3. Valid whenever `busy` is high.
- `blk_idx`, output, 16: index of the current block within the stage.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the full network run completes.
- `status`, output, 32: status word, laid out as follows.
  - [31] busy
  - [30] done_sticky
  - [29] err_sticky
  - [28] abort_sticky
  - [17:16] layer
  - [15:0] blk_idx
  - All other bits are 0.
- `perf_cycles`, output, 32: busy-cycle counter (see Configuration).

## Operation
- `ctrl_q` registers `control_reg` every cycle.
- The start event is `control_reg[1] & ~ctrl_q[1]`. Holding bit 1 high never re-triggers a run.
- States are IDLE, ISSUE, WAIT, DRAIN and DONE.
  - **IDLE:** on a start event, go to ISSUE with layer=0 and blk_idx=0. Clear done_sticky, err_sticky and abort_sticky.
  - **ISSUE:** `blk_start`=1, which is a Moore output. Always go to WAIT.
  - **WAIT:** on `blk_done`:
    - If blk_idx == Ln_BLOCKS−1 for the current layer, go to DRAIN.
    - Otherwise increment blk_idx and go to ISSUE.
  - **DRAIN:** wait while `wr_idle`=0. When `wr_idle`=1:
    - If layer==3, go to DONE.
    - Otherwise increment layer, set blk_idx=0 and go to ISSUE.
  - **DONE:** `done`=1 for one cycle and done_sticky is set. Go to IDLE. blk_idx and layer hold their final values.
- Abort: `control_reg[2]` sampled 1 in any non-IDLE state moves to IDLE on the next edge and sets abort_sticky. layer and blk_idx are cleared.
  - Abort takes priority over `blk_done` and `wr_idle` in the same cycle.
  - In IDLE, abort=1 suppresses a simultaneous start event.
- A start event while busy is ignored.
- A `blk_done` sampled in any state other than WAIT sets err_sticky and changes nothing else.
- The stage-count compare uses the parameter selected by `layer`. blk_idx never exceeds Ln_BLOCKS−1 and never wraps.

## Timing
- Reset values: every output and every sticky bit is 0, state=IDLE, `ctrl_q`=0.
- The start event is sampled at edge k. `blk_start` is high during cycle k+1.
- Earliest `blk_done` accepted is in the cycle after `blk_start` (in WAIT). The next `blk_start` follows 1 cycle after the accepted `blk_done`.
  - Minimum block period is 2 cycles.
- Stage switch: DRAIN is entered after the last `blk_done`. It costs at least 1 cycle, plus however many cycles `wr_idle` stays low. `blk_start` for the new stage follows the cycle in which `wr_idle`=1 is sampled.
- `done` is asserted 1 cycle after DRAIN samples `wr_idle`=1 in layer 3. `busy` drops in the following cycle.
- Reset asserted mid-run returns everything to reset values immediately, without waiting for a clock edge.

## Configuration
- Macro `CNN_SCHED_PERF_EN`.
- **Defined:** `perf_cycles` counts cycles with `busy`=1.
  - It is cleared on a start event and holds its value in IDLE.
  - It saturates at 32'hFFFF_FFFF.
- **Undefined:** `perf_cycles` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
Unless a scenario says otherwise, parameters are `L0..L3` = 2, 1, 3, 1.
- **Reset:** assert `reset` mid-WAIT. All outputs read 0 asynchronously, and `status`=0 after release.
- **Full run:** `blk_done` 3 cycles after each `blk_start`, `wr_idle`=1.
  - Exactly 7 `blk_start` pulses.
  - (layer, idx) sequence is (0,0) (0,1) (1,0) (2,0) (2,1) (2,2) (3,0).
  - One `done` pulse, then `status`=32'h4003_0000.
- **Drain stall:** `wr_idle`=0 for 20 cycles after the last stage-0 `blk_done`.
  - No `blk_start` during the stall.
  - `blk_start` with layer=1, idx=0 appears 1 cycle after `wr_idle` rises.
- **Abort collision:** `control_reg`=32'h4 in the same cycle as a stage-2 `blk_done`. Next cycle `busy`=0, status[28]=1, and no further `blk_start`.
- **Held start:** `control_reg` held at 32'h2 through completion. No second run occurs. Writing 0 and then 2 restarts the run and clears status[30].
- **Spurious done and perf:**
  - A `blk_done` pulse while in IDLE sets status[29] and the state stays IDLE.
  - With `CNN_SCHED_PERF_EN` defined, `perf_cycles` equals the number of busy cycles measured in the full-run scenario.
